// File: rtl/rv_pkg.sv
// Shared RV64 core constants: datapath width, register index width, load funct3 encodings.
package rv_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned REG_W = 5;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

endpackage

// File: rtl/rv_wb_fifo.sv
// Synchronous FIFO buffering ALU results for the writeback stage; same-cycle push and pop allowed.
module rv_wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/rv_wb.sv
// RV64 writeback: arbitrates buffered ALU results against load completions onto the RF write port.
// Optional combinational forwarding ports are enabled by defining RV_WB_BYPASS_EN.
module rv_wb #(
    parameter int unsigned XLEN       = rv_pkg::XLEN,
    parameter int unsigned ALU_DEPTH  = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            alu_vld_i,
    output logic            alu_rdy_o,
    input  logic [4:0]      alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    input  logic            lsu_vld_i,
    output logic            lsu_rdy_o,
    input  logic [4:0]      lsu_rd_i,
    input  logic [XLEN-1:0] lsu_data_i,
    input  logic [2:0]      lsu_funct3_i,
    input  logic [2:0]      lsu_addr_lo_i,
    input  logic            pend_set_i,
    input  logic [4:0]      pend_rd_i,
    output logic [31:0]     pend_o,
`ifdef RV_WB_BYPASS_EN
    output logic            fwd_vld_o,
    output logic [4:0]      fwd_reg_o,
    output logic [XLEN-1:0] fwd_data_o,
`endif
    output logic            wr_en_o,
    output logic [4:0]      wr_reg_o,
    output logic [XLEN-1:0] wr_data_o
);

    import rv_pkg::*;

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [REG_W+XLEN-1:0] fifo_head;
    logic                  alu_push, alu_cand, alu_grant, lsu_grant;
    logic [REG_W-1:0]      cand_rd;
    logic [XLEN-1:0]       cand_data;
    logic [XLEN-1:0]       ld_shift, ld_ext;
    logic                  win_vld;
    logic [REG_W-1:0]      win_rd;
    logic [XLEN-1:0]       win_data;

    logic [SW-1:0]         starve_q, starve_d;
    logic [31:0]           pend_q, pend_d;
    logic                  wr_en_q, wr_en_d;
    logic [REG_W-1:0]      wr_reg_q, wr_reg_d;
    logic [XLEN-1:0]       wr_data_q, wr_data_d;

    rv_wb_fifo #(
        .WIDTH (REG_W + XLEN),
        .DEPTH (ALU_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  ({alu_rd_i, alu_data_i}),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    // An empty FIFO presents the incoming ALU result directly; it is only stored if it loses.
    assign alu_rdy_o = ~fifo_full;
    assign alu_push  = alu_vld_i & ~fifo_full;
    assign alu_cand  = ~fifo_empty | alu_push;
    assign cand_rd   = fifo_empty ? alu_rd_i   : fifo_head[REG_W+XLEN-1:XLEN];
    assign cand_data = fifo_empty ? alu_data_i : fifo_head[XLEN-1:0];

    assign lsu_rdy_o = (starve_q != STARVE_LIM);
    assign lsu_grant = lsu_vld_i & lsu_rdy_o;
    assign alu_grant = alu_cand & ~lsu_grant;
    assign fifo_push = alu_push & ~(fifo_empty & alu_grant);
    assign fifo_pop  = alu_grant & ~fifo_empty;

    always_comb begin
        ld_shift = lsu_data_i >> {lsu_addr_lo_i, 3'b000};
        case (lsu_funct3_i)
            LB:      ld_ext = {{(XLEN-8){ld_shift[7]}},   ld_shift[7:0]};
            LH:      ld_ext = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            LW:      ld_ext = {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
            LBU:     ld_ext = {{(XLEN-8){1'b0}},          ld_shift[7:0]};
            LHU:     ld_ext = {{(XLEN-16){1'b0}},         ld_shift[15:0]};
            LWU:     ld_ext = {{(XLEN-32){1'b0}},         ld_shift[31:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    assign win_vld  = lsu_grant | alu_grant;
    assign win_rd   = lsu_grant ? lsu_rd_i : cand_rd;
    assign win_data = lsu_grant ? ld_ext   : cand_data;

    always_comb begin
        starve_d = starve_q;
        if (alu_grant)
            starve_d = '0;
        else if (lsu_grant && !fifo_empty)
            starve_d = starve_q + 1'b1;

        wr_en_d   = win_vld & (win_rd != '0);
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        if (win_vld) begin
            wr_reg_d  = win_rd;
            wr_data_d = win_data;
        end

        // Set is applied after clear so a same-cycle re-dispatch keeps the bit.
        pend_d = pend_q;
        if (lsu_grant)                       pend_d[lsu_rd_i]  = 1'b0;
        if (pend_set_i && pend_rd_i != '0)   pend_d[pend_rd_i] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q  <= '0;
            pend_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            starve_q  <= starve_d;
            pend_q    <= pend_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign pend_o    = pend_q;
    assign wr_en_o   = wr_en_q;
    assign wr_reg_o  = wr_reg_q;
    assign wr_data_o = wr_data_q;

`ifdef RV_WB_BYPASS_EN
    assign fwd_vld_o  = win_vld & (win_rd != '0) & ~rst_i;
    assign fwd_reg_o  = win_rd;
    assign fwd_data_o = win_data;
`endif

endmodule

// File: tb/tb_rv_wb.sv
// Directed bench for rv_wb: table of single-transaction vectors plus hand sequences for arbitration and scoreboard.
module tb_rv_wb;

    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        alu_vld_i = 1'b0;
    logic        alu_rdy_o;
    logic [4:0]  alu_rd_i = '0;
    logic [63:0] alu_data_i = '0;
    logic        lsu_vld_i = 1'b0;
    logic        lsu_rdy_o;
    logic [4:0]  lsu_rd_i = '0;
    logic [63:0] lsu_data_i = '0;
    logic [2:0]  lsu_funct3_i = '0;
    logic [2:0]  lsu_addr_lo_i = '0;
    logic        pend_set_i = 1'b0;
    logic [4:0]  pend_rd_i = '0;
    logic [31:0] pend_o;
    logic        wr_en_o;
    logic [4:0]  wr_reg_o;
    logic [63:0] wr_data_o;
`ifdef RV_WB_BYPASS_EN
    logic        fwd_vld_o;
    logic [4:0]  fwd_reg_o;
    logic [63:0] fwd_data_o;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rv_wb #(
        .XLEN       (64),
        .ALU_DEPTH  (2),
        .STARVE_MAX (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .alu_vld_i     (alu_vld_i),
        .alu_rdy_o     (alu_rdy_o),
        .alu_rd_i      (alu_rd_i),
        .alu_data_i    (alu_data_i),
        .lsu_vld_i     (lsu_vld_i),
        .lsu_rdy_o     (lsu_rdy_o),
        .lsu_rd_i      (lsu_rd_i),
        .lsu_data_i    (lsu_data_i),
        .lsu_funct3_i  (lsu_funct3_i),
        .lsu_addr_lo_i (lsu_addr_lo_i),
        .pend_set_i    (pend_set_i),
        .pend_rd_i     (pend_rd_i),
        .pend_o        (pend_o),
`ifdef RV_WB_BYPASS_EN
        .fwd_vld_o     (fwd_vld_o),
        .fwd_reg_o     (fwd_reg_o),
        .fwd_data_o    (fwd_data_o),
`endif
        .wr_en_o       (wr_en_o),
        .wr_reg_o      (wr_reg_o),
        .wr_data_o     (wr_data_o)
    );

    typedef struct {
        logic        alu_vld;
        logic [4:0]  alu_rd;
        logic [63:0] alu_data;
        logic        lsu_vld;
        logic [4:0]  lsu_rd;
        logic [63:0] lsu_data;
        logic [2:0]  f3;
        logic [2:0]  off;
        logic        exp_en;
        logic [4:0]  exp_reg;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_vld_i  = 1'b0;
        lsu_vld_i  = 1'b0;
        pend_set_i = 1'b0;
    endtask

    task automatic drive_lsu(input logic [4:0] rd, input logic [63:0] d,
                             input logic [2:0] f3, input logic [2:0] off);
        lsu_vld_i     = 1'b1;
        lsu_rd_i      = rd;
        lsu_data_i    = d;
        lsu_funct3_i  = f3;
        lsu_addr_lo_i = off;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [63:0] d);
        alu_vld_i  = 1'b1;
        alu_rd_i   = rd;
        alu_data_i = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'h0, LD, 3'd0, 1'b1, 5'd5, 64'h1234};
        vecs[1]  = '{1'b1, 5'd0, 64'hABCD, 1'b0, 5'd0, 64'h0, LD, 3'd0, 1'b0, 5'd0, 64'h0};
        vecs[2]  = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd1, 64'h0000_0000_8000_0000, LB,  3'd3, 1'b1, 5'd1, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[3]  = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd2, 64'h0000_0000_8000_0000, LBU, 3'd3, 1'b1, 5'd2, 64'h0000_0000_0000_0080};
        vecs[4]  = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd3, 64'h8765_4321_0000_0000, LW,  3'd4, 1'b1, 5'd3, 64'hFFFF_FFFF_8765_4321};
        vecs[5]  = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd4, 64'h8765_4321_0000_0000, LWU, 3'd4, 1'b1, 5'd4, 64'h0000_0000_8765_4321};
        vecs[6]  = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 64'h8765_4321_0000_0000, LH,  3'd6, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_8765};
        vecs[7]  = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd6, 64'h0000_0000_F00D_1234, LHU, 3'd2, 1'b1, 5'd6, 64'h0000_0000_0000_F00D};
        vecs[8]  = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'h0123_4567_89AB_CDEF, LD,  3'd0, 1'b1, 5'd7, 64'h0123_4567_89AB_CDEF};
        vecs[9]  = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd8, 64'hFEDC_BA98_7654_3210, 3'b111, 3'd0, 1'b1, 5'd8, 64'hFEDC_BA98_7654_3210};
        vecs[10] = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd9, 64'h1111_1111_1111_117F, LB,  3'd0, 1'b1, 5'd9, 64'h0000_0000_0000_007F};
        vecs[11] = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd10, 64'h0000_0000_0000_7FFF, LH, 3'd0, 1'b1, 5'd10, 64'h0000_0000_0000_7FFF};
        vecs[12] = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd31, 64'hFFFF_FFFF_7FFF_FFFF, LW, 3'd0, 1'b1, 5'd31, 64'h0000_0000_7FFF_FFFF};
        vecs[13] = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 64'h8000_0000_0000_0000, LB,  3'd7, 1'b0, 5'd0, 64'h0};

        // Reset held two cycles
        step();
        step();
        rst_i = 1'b0;
        chk("reset_wr_en", 64'(wr_en_o), 64'd0);
        chk("reset_wr_reg", 64'(wr_reg_o), 64'd0);
        chk("reset_wr_data", wr_data_o, 64'd0);
        chk("reset_pend", 64'(pend_o), 64'd0);
        chk("reset_alu_rdy", 64'(alu_rdy_o), 64'd1);

        for (int i = 0; i < 14; i++) begin
            alu_vld_i  = vecs[i].alu_vld;
            alu_rd_i   = vecs[i].alu_rd;
            alu_data_i = vecs[i].alu_data;
            if (vecs[i].lsu_vld)
                drive_lsu(vecs[i].lsu_rd, vecs[i].lsu_data, vecs[i].f3, vecs[i].off);
            else
                lsu_vld_i = 1'b0;
`ifdef RV_WB_BYPASS_EN
            #1;
            chk($sformatf("vec%0d_fwd_vld", i), 64'(fwd_vld_o), 64'(vecs[i].exp_en));
            if (vecs[i].exp_en)
                chk($sformatf("vec%0d_fwd_data", i), fwd_data_o, vecs[i].exp_data);
`endif
            step();
            chk($sformatf("vec%0d_wr_en", i), 64'(wr_en_o), 64'(vecs[i].exp_en));
            if (vecs[i].exp_en) begin
                chk($sformatf("vec%0d_wr_reg", i), 64'(wr_reg_o), 64'(vecs[i].exp_reg));
                chk($sformatf("vec%0d_wr_data", i), wr_data_o, vecs[i].exp_data);
            end
        end
        idle();
        step();
        chk("idle_no_write", 64'(wr_en_o), 64'd0);

        // Conflict: LSU wins, buffered ALU result follows a cycle later
        drive_alu(5'd3, 64'h33);
        drive_lsu(5'd4, 64'h44, LD, 3'd0);
        step();
        chk("conflict_lsu_reg", 64'(wr_reg_o), 64'd4);
        chk("conflict_lsu_data", wr_data_o, 64'h44);
        idle();
        step();
        chk("conflict_alu_en", 64'(wr_en_o), 64'd1);
        chk("conflict_alu_reg", 64'(wr_reg_o), 64'd3);
        chk("conflict_alu_data", wr_data_o, 64'h33);

        // Fill FIFO while LSU keeps the slot busy
        drive_alu(5'd11, 64'hB);
        drive_lsu(5'd0, 64'h0, LD, 3'd0);
        step();
        drive_alu(5'd12, 64'hC);
        step();
        chk("fifo_full_rdy", 64'(alu_rdy_o), 64'd0);
        idle();
        step();
        chk("drain_reg11", 64'(wr_reg_o), 64'd11);
        step();
        chk("drain_reg12", 64'(wr_reg_o), 64'd12);
        step();
        chk("drain_done", 64'(wr_en_o), 64'd0);

        // Starvation: LSU held valid, one ALU result waiting
        for (int k = 0; k < 5; k++) begin
            if (k == 0) drive_alu(5'd13, 64'hD);
            else        alu_vld_i = 1'b0;
            drive_lsu(5'(20 + k), 64'(256 + k), LD, 3'd0);
            #1;
            chk($sformatf("starve_lsu_rdy%0d", k), 64'(lsu_rdy_o), 64'd1);
            step();
            chk($sformatf("starve_lsu_wr%0d", k), 64'(wr_reg_o), 64'(20 + k));
        end
        drive_lsu(5'd25, 64'h200, LD, 3'd0);
        #1;
        chk("starve_forced_rdy", 64'(lsu_rdy_o), 64'd0);
        step();
        chk("starve_alu_reg", 64'(wr_reg_o), 64'd13);
        chk("starve_alu_data", wr_data_o, 64'hD);
        chk("starve_rdy_back", 64'(lsu_rdy_o), 64'd1);
        step();
        chk("starve_held_lsu", 64'(wr_reg_o), 64'd25);
        chk("starve_held_data", wr_data_o, 64'h200);
        idle();
        step();

        // Scoreboard
        pend_set_i = 1'b1;
        pend_rd_i  = 5'd7;
        step();
        chk("pend_set7", 64'(pend_o), 64'h80);
        pend_set_i = 1'b0;
        drive_lsu(5'd7, 64'h77, LD, 3'd0);
        step();
        chk("pend_clr7", 64'(pend_o), 64'h0);
        chk("pend_clr7_wr", 64'(wr_reg_o), 64'd7);
        idle();
        pend_set_i = 1'b1;
        pend_rd_i  = 5'd7;
        step();
        drive_lsu(5'd7, 64'h78, LD, 3'd0);
        step();
        chk("pend_set_wins", 64'(pend_o), 64'h80);
        chk("pend_set_wins_wr", wr_data_o, 64'h78);
        lsu_vld_i = 1'b0;
        pend_rd_i = 5'd0;
        step();
        chk("pend_rd0_ignored", 64'(pend_o), 64'h80);
        pend_rd_i = 5'd31;
        step();
        chk("pend_set31", 64'(pend_o), 64'h8000_0080);
        idle();
        step();

        // Reset mid-stream discards buffered results
        drive_alu(5'd9, 64'h9);
        drive_lsu(5'd0, 64'h0, LD, 3'd0);
        step();
        drive_alu(5'd10, 64'hA);
        step();
        drive_alu(5'd14, 64'hE);
        step();
        idle();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        chk("midrst_pend", 64'(pend_o), 64'h0);
        chk("midrst_alu_rdy", 64'(alu_rdy_o), 64'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("midrst_no_write%0d", k), 64'(wr_en_o), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_wb.md
Name: rv_wb

Overview:
- Writeback stage of the RV64 core; the producer side of the register-file write port (wr_reg/wr_data).
- Merges two result sources into the single RF write port:
  - ALU results, buffered in a small FIFO.
  - LSU load completions, aligned and sign/zero-extended here.
- Keeps a load scoreboard of destination registers with a load in flight, so issue can stall on RAW hazards.

Parameters:
- XLEN, 64, datapath width.
- ALU_DEPTH, 2, ALU result FIFO depth; power of two, at least 2.
- STARVE_MAX, 4, consecutive LSU-won cycles with the ALU FIFO non-empty before the ALU is forced a grant.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous, active-high reset.
- alu_vld_i  in  1  ALU result valid.
- alu_rdy_o  out  1  ALU FIFO not full.
- alu_rd_i  in  5  ALU destination register.
- alu_data_i  in  XLEN  ALU result.
- lsu_vld_i  in  1  load data valid.
- lsu_rdy_o  out  1  load accepted this cycle.
- lsu_rd_i  in  5  load destination register.
- lsu_data_i  in  XLEN  raw aligned doubleword from memory.
- lsu_funct3_i  in  3  load type.
- lsu_addr_lo_i  in  3  byte offset within the doubleword.
- pend_set_i  in  1  issue stage dispatched a load.
- pend_rd_i  in  5  destination register of that load.
- pend_o  out  32  scoreboard, one bit per register; bit 0 is always 0.
- wr_en_o  out  1  RF write enable (registered).
- wr_reg_o  out  5  RF write address (registered).
- wr_data_o  out  XLEN  RF write data (registered).

Behaviour:
Reset:
- rst_i is sampled on the clk_i edge; reset is synchronous and active-high.
- On reset: wr_en_o=0, wr_reg_o=0, wr_data_o=0, pend_o=0, FIFO empty, starve counter=0.
- alu_rdy_o=1 in the cycle after reset.
- Reset mid-operation discards FIFO contents and any in-flight write; nothing is written after reset.

Handshake:
- ALU transfer occurs when alu_vld_i & alu_rdy_o.
- LSU transfer occurs when lsu_vld_i & lsu_rdy_o.
- Inputs must stay stable while valid is high and ready is low.

ALU path and arbitration:
- Accepted ALU results enter the FIFO.
- The FIFO head and lsu_vld_i compete for the write slot each cycle.
- Default priority: LSU wins, so lsu_rdy_o=1.
- Starve counter:
  - Increments each cycle the LSU wins while the FIFO is non-empty.
  - When it equals STARVE_MAX: lsu_rdy_o=0 for one cycle, the FIFO head is popped, and the counter clears.
  - Also clears whenever the ALU is granted.
- With an empty FIFO and no load, nothing is written.
- Simultaneous push and pop on a full FIFO is allowed; alu_rdy_o reflects the pre-pop state (full means not ready).

Latency:
- The write is registered: the winner appears on wr_en_o/wr_reg_o/wr_data_o on the cycle after grant.
- ALU minimum latency is 1 cycle (accepted into an empty FIFO and granted the same cycle through the FIFO bypass).

x0:
- A winner with rd=0 is consumed but wr_en_o stays 0.

Load extension:
- Byte select = lsu_data_i >> (8*lsu_addr_lo_i).
- Extension by lsu_funct3_i:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend halfword.
  - 010 LW: sign-extend word.
  - 011 LD: full doubleword.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend halfword.
  - 110 LWU: zero-extend word.
  - 111: treated as LD.
- Misalignment across a doubleword is excluded upstream and not checked.

Scoreboard:
- pend_set_i with pend_rd_i≠0 sets the bit on the next edge.
- The bit clears on the edge on which the LSU write for that register is granted.
- Set and clear of the same register in the same cycle: set wins.
- pend_rd_i=0 is ignored.

Optional Feature:
- Macro: RV_WB_BYPASS_EN.
- Defined: adds ports fwd_vld_o (1), fwd_reg_o (5), fwd_data_o (XLEN).
  - They present the granted, extended result combinationally in the grant cycle, one cycle before wr_en_o.
  - fwd_vld_o=0 for rd=0 and during reset.
- Undefined: these ports and their logic are absent; the rest of the behaviour is identical.

Decomposition:
- rv_pkg holds:
  - XLEN.
  - Load funct3 localparams: LB, LH, LW, LD, LBU, LHU, LWU.
  - Register-index width (5).
- Sub-module rv_wb_fifo: synchronous FIFO for the ALU results.
  - Parameters: width, depth.
  - Outputs: full, empty, head.
  - Supports same-cycle push and pop.
- Arbiter, extension logic and scoreboard stay in rv_wb.

Test Plan:
1. Reset: hold rst_i 2 cycles -> wr_en_o=0, pend_o=0, alu_rdy_o=1; drop reset mid-stream after 3 pushes -> no later write.
2. ALU single: rd=5, data 0x1234 accepted at cycle t -> wr_en_o=1, wr_reg_o=5, wr_data_o=0x1234 at t+1; rd=0 -> no wr_en_o.
3. Loads with lsu_data_i=0x0000_0000_8000_0000 and addr_lo=3:
   - LB -> 0xFFFF_FFFF_FFFF_FF80.
   - LBU -> 0x80.
   - LW at addr_lo=4 with 0x8765_4321_0000_0000 -> 0xFFFF_FFFF_8765_4321.
4. Conflict: ALU rd=3 and LSU rd=4 in the same cycle -> reg 4 written at t+1, reg 3 at t+2; 2 more ALU pushes with LSU busy -> alu_rdy_o=0.
5. Starvation: lsu_vld_i held high, FIFO non-empty -> after 4 LSU grants lsu_rdy_o=0 for one cycle and an ALU write occurs.
6. Scoreboard:
   - pend_set rd=7 -> pend_o[7]=1; LSU rd=7 granted -> bit clears the same edge as the write register loads.
   - Set rd=7 in the grant cycle -> bit stays 1.
   - Set rd=0 -> pend_o unchanged.
